pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the CPU pipeline.
- Replaces the hand-written per-stage registers (ID/EX, EX/MEM, ...) with one block instantiated at any stage boundary.
- Carries an opaque payload bus plus valid and delay-slot state.
- Implements the stall-vector bubble/hold rules and a flush, and tracks hold duration.

Parameters:
- DATA_W, 128, payload width in bits; the caller packs aluop/alusel/operands/wd/wreg/inst/link address.
- STALL_W, 6, width of the stall vector from CTRL.
- STAGE_IDX, 2, stall bit of the upstream stage; the downstream stall bit is STAGE_IDX+1, so STAGE_IDX+1 < STALL_W is required (elaboration error otherwise).
- NOP_VALUE, {DATA_W{1'b0}}, payload driven when a bubble or flush is inserted.
- HOLD_W, 4, width of the saturating hold-cycle counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- stall  in  STALL_W  per-stage stall request from CTRL, 1 = stop
- flush  in  1  discard stage contents (exception/redirect)
- in_valid  in  1  upstream payload is a real instruction
- in_data  in  DATA_W  upstream payload
- in_ds  in  1  upstream instruction is in a delay slot
- in_next_ds  in  1  upstream instruction is a branch, so the next instruction is in a delay slot
- out_valid  out  1  registered valid
- out_data  out  DATA_W  registered payload
- out_ds  out  1  registered in-delay-slot flag to downstream
- next_ds_o  out  1  registered next-in-delay-slot flag fed back to ID
- bubble_o  out  1  1 when the current output was created by bubble or flush
- hold_cnt  out  HOLD_W  consecutive hold cycles, saturating
- hold_sat  out  1  hold_cnt == all ones
- perf_bubbles  out  32  bubble count (see Optional Feature)
- perf_captures  out  32  capture count (see Optional Feature)

Behaviour:
- Let S_up = stall[STAGE_IDX] and S_dn = stall[STAGE_IDX+1].
- Reset (asynchronous, rst = 1, immediate with no clock edge needed):
  - out_valid = 0, out_data = NOP_VALUE, out_ds = 0, next_ds_o = 0.
  - bubble_o = 1, hold_cnt = 0, hold_sat = 0, perf counters = 0.
- Reset asserted mid-hold discards the held payload; the first edge after release evaluates the rules below normally.
- Per rising edge when rst = 0, first matching rule wins:
  1. flush = 1:
     - out_valid = 0, out_data = NOP_VALUE, out_ds = 0, next_ds_o = 0, bubble_o = 1, hold_cnt = 0.
     - Flush overrides any stall combination.
  2. S_up = 1, S_dn = 0 (bubble):
     - out_valid = 0, out_data = NOP_VALUE, out_ds = 0, bubble_o = 1, hold_cnt = 0.
     - next_ds_o holds its value so a stalled branch keeps its delay-slot marking for ID.
  3. S_up = 0 (capture):
     - out_valid = in_valid, out_data = in_valid ? in_data : NOP_VALUE.
     - out_ds = in_ds & in_valid, next_ds_o = in_next_ds & in_valid.
     - bubble_o = 0, hold_cnt = 0.
     - Capture applies even if S_dn = 1; CTRL never generates that combination and the block does not check it.
  4. S_up = 1, S_dn = 1 (hold):
     - All payload and flag outputs keep their values.
     - hold_cnt increments and saturates at 2^HOLD_W-1; it never wraps.
- hold_sat is combinational from hold_cnt.
- Latency: in_* to out_* is 1 cycle. There is no combinational path from inputs to outputs.
- in_* are ignored whenever rule 1, 2 or 4 applies.

Optional Feature:
- Macro: PIPE_STAGE_PERF_CNT_EN.
- When defined:
  - perf_bubbles increments on every rule-1 or rule-2 edge.
  - perf_captures increments on every rule-3 edge with in_valid = 1.
  - Both are 32-bit, wrap modulo 2^32, and are cleared by rst.
- When undefined: no counter flops; perf_bubbles and perf_captures are tied to 0.

Test Plan:
- rst = 1 mid-run with in_data = 0xDEAD..., no clock edge -> outputs go immediately to NOP_VALUE/0, bubble_o = 1. Release rst, then one edge with in_valid = 1 and stall = 0 -> out_data = in_data, bubble_o = 0.
- STAGE_IDX = 2, stall = 6'b000100, in_valid = 1, in_next_ds = 1 captured the cycle before -> out_valid = 0, out_data = NOP_VALUE, next_ds_o stays 1.
- stall = 6'b001100 for 20 cycles with HOLD_W = 4 -> out_data unchanged; hold_cnt reaches 15 on the 15th hold edge and stays 15; hold_sat = 1. Then stall = 0 -> hold_cnt = 0, new capture.
- flush = 1 together with stall = 6'b001100 -> out_valid = 0, out_ds = 0, next_ds_o = 0, bubble_o = 1.
- stall = 0, in_valid = 1, in_ds = 1, in_next_ds = 0 -> out_ds = 1. Next edge with in_valid = 0, in_ds = 1 -> out_ds = 0, out_data = NOP_VALUE.
- With PIPE_STAGE_PERF_CNT_EN: 3 captures, 2 bubbles, 1 flush -> perf_captures = 3, perf_bubbles = 3. Without the macro -> both read 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register: payload, valid and delay-slot flags with
// stall-vector bubble/hold rules, flush, and a saturating hold-cycle counter.
// Define PIPE_STAGE_PERF_CNT_EN to build the bubble/capture performance counters.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 128,
  parameter int unsigned       STALL_W   = 6,
  parameter int unsigned       STAGE_IDX = 2,
  parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
  parameter int unsigned       HOLD_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_ds,
  input  logic               in_next_ds,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_ds,
  output logic               next_ds_o,
  output logic               bubble_o,
  output logic [HOLD_W-1:0]  hold_cnt,
  output logic               hold_sat,
  output logic [31:0]        perf_bubbles,
  output logic [31:0]        perf_captures
);

  localparam int unsigned DnIdx = STAGE_IDX + 1;

  if (DnIdx >= STALL_W) begin : gen_bad_stage_idx
    $error("pipe_stage_reg: STAGE_IDX+1 must be below STALL_W");
  end

  typedef enum logic [1:0] {
    ActFlush,
    ActBubble,
    ActCapture,
    ActHold
  } action_e;

  action_e action;

  logic              s_up;
  logic              s_dn;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ds_q, ds_d;
  logic              next_ds_q, next_ds_d;
  logic              bubble_q, bubble_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  assign s_up = stall[STAGE_IDX];
  assign s_dn = stall[DnIdx];

  // Priority decode: flush beats every stall pattern; S_up=0 captures regardless of S_dn.
  always_comb begin
    action = ActCapture;
    if (flush) begin
      action = ActFlush;
    end else if (s_up && !s_dn) begin
      action = ActBubble;
    end else if (!s_up) begin
      action = ActCapture;
    end else begin
      action = ActHold;
    end
  end

  always_comb begin
    valid_d   = valid_q;
    data_d    = data_q;
    ds_d      = ds_q;
    next_ds_d = next_ds_q;
    bubble_d  = bubble_q;
    hold_d    = hold_q;
    unique case (action)
      ActFlush: begin
        valid_d   = 1'b0;
        data_d    = NOP_VALUE;
        ds_d      = 1'b0;
        next_ds_d = 1'b0;
        bubble_d  = 1'b1;
        hold_d    = '0;
      end
      ActBubble: begin
        // next_ds is kept so a stalled branch still marks its delay slot for ID.
        valid_d  = 1'b0;
        data_d   = NOP_VALUE;
        ds_d     = 1'b0;
        bubble_d = 1'b1;
        hold_d   = '0;
      end
      ActCapture: begin
        valid_d   = in_valid;
        data_d    = in_valid ? in_data : NOP_VALUE;
        ds_d      = in_ds & in_valid;
        next_ds_d = in_next_ds & in_valid;
        bubble_d  = 1'b0;
        hold_d    = '0;
      end
      ActHold: begin
        if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      data_q    <= NOP_VALUE;
      ds_q      <= 1'b0;
      next_ds_q <= 1'b0;
      bubble_q  <= 1'b1;
      hold_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      data_q    <= data_d;
      ds_q      <= ds_d;
      next_ds_q <= next_ds_d;
      bubble_q  <= bubble_d;
      hold_q    <= hold_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ds    = ds_q;
  assign next_ds_o = next_ds_q;
  assign bubble_o  = bubble_q;
  assign hold_cnt  = hold_q;
  assign hold_sat  = &hold_q;

`ifdef PIPE_STAGE_PERF_CNT_EN
  logic [31:0] perf_bub_q, perf_bub_d;
  logic [31:0] perf_cap_q, perf_cap_d;

  always_comb begin
    perf_bub_d = perf_bub_q;
    perf_cap_d = perf_cap_q;
    if (action == ActFlush || action == ActBubble) begin
      perf_bub_d = perf_bub_q + 32'd1;
    end
    if (action == ActCapture && in_valid) begin
      perf_cap_d = perf_cap_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bub_q <= '0;
      perf_cap_q <= '0;
    end else begin
      perf_bub_q <= perf_bub_d;
      perf_cap_q <= perf_cap_d;
    end
  end

  assign perf_bubbles  = perf_bub_q;
  assign perf_captures = perf_cap_q;
`else
  assign perf_bubbles  = 32'd0;
  assign perf_captures = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized self-checking bench for pipe_stage_reg against a rule-level reference model.
module tb_pipe_stage_reg;

  localparam int DW = 128;
  localparam int SW = 6;
  localparam int HW = 4;
  localparam int HMAX = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] stall;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ds;
  logic          in_next_ds;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ds;
  logic          next_ds_o;
  logic          bubble_o;
  logic [HW-1:0] hold_cnt;
  logic          hold_sat;
  logic [31:0]   perf_bubbles;
  logic [31:0]   perf_captures;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic          m_valid, m_ds, m_nds, m_bub;
  logic [DW-1:0] m_data;
  int            m_hold;
  logic [31:0]   m_pb, m_pc;

  pipe_stage_reg #(
    .DATA_W   (DW),
    .STALL_W  (SW),
    .STAGE_IDX(2),
    .NOP_VALUE({DW{1'b0}}),
    .HOLD_W   (HW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ds        (in_ds),
    .in_next_ds   (in_next_ds),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ds       (out_ds),
    .next_ds_o    (next_ds_o),
    .bubble_o     (bubble_o),
    .hold_cnt     (hold_cnt),
    .hold_sat     (hold_sat),
    .perf_bubbles (perf_bubbles),
    .perf_captures(perf_captures)
  );

  always #5 clk = ~clk;

  wire [200:0] act_vec = {out_valid, out_data, out_ds, next_ds_o, bubble_o, hold_cnt, hold_sat,
                          perf_bubbles, perf_captures};

  function automatic logic [200:0] exp_vec();
    logic [31:0] pb, pc;
`ifdef PIPE_STAGE_PERF_CNT_EN
    pb = m_pb;
    pc = m_pc;
`else
    pb = 32'd0;
    pc = 32'd0;
`endif
    return {m_valid, m_data, m_ds, m_nds, m_bub, 4'(m_hold), (m_hold == HMAX), pb, pc};
  endfunction

  function automatic logic [DW-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = '0; m_ds = 1'b0; m_nds = 1'b0; m_bub = 1'b1;
    m_hold = 0; m_pb = 32'd0; m_pc = 32'd0;
  endtask

  // Drive one cycle of inputs, take the edge, apply the rule table to the model.
  task automatic step(input logic [SW-1:0] st, input logic fl, input logic v,
                      input logic [DW-1:0] d, input logic ds, input logic nds);
    stall = st; flush = fl; in_valid = v; in_data = d; in_ds = ds; in_next_ds = nds;
    @(posedge clk);
    if (fl) begin
      m_valid = 0; m_data = '0; m_ds = 0; m_nds = 0; m_bub = 1; m_hold = 0; m_pb = m_pb + 1;
    end else if (st[2] && !st[3]) begin
      m_valid = 0; m_data = '0; m_ds = 0; m_bub = 1; m_hold = 0; m_pb = m_pb + 1;
    end else if (!st[2]) begin
      m_valid = v; m_data = v ? d : '0; m_ds = ds && v; m_nds = nds && v; m_bub = 0;
      m_hold = 0;
      if (v) m_pc = m_pc + 1;
    end else begin
      m_hold = (m_hold + 1 > HMAX) ? HMAX : m_hold + 1;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_async_reset();
    step(6'b000000, 0, 1, rand_data(), 0, 1);
    for (int i = 0; i < 3; i++) step(6'b001100, 0, 1, rand_data(), 0, 0);
    in_data = {4{32'hDEADBEEF}};
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || bubble_o !== 1'b1 || hold_cnt !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: valid=%b data=%h bub=%b hold=%0d want 0/0/1/0",
               out_valid, out_data, bubble_o, hold_cnt);
    end
    #1;
    rst = 1'b0;
    step(6'b000000, 0, 1, {4{32'hDEADBEEF}}, 0, 0);
    checks++;
    if (out_data !== {4{32'hDEADBEEF}} || bubble_o !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_capture: data=%h bub=%b valid=%b", out_data, bubble_o, out_valid);
    end
  endtask

  task automatic test_bubble();
    step(6'b000000, 0, 1, rand_data(), 0, 1);
    step(6'b000100, 0, 1, rand_data(), 1, 0);
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || next_ds_o !== 1'b1 || bubble_o !== 1'b1) begin
      errors++;
      $display("FAIL bubble: valid=%b data=%h next_ds=%b bub=%b want 0/0/1/1",
               out_valid, out_data, next_ds_o, bubble_o);
    end
    checks++;
    if (act_vec !== exp_vec()) begin
      errors++;
      $display("FAIL bubble_model: got %h want %h", act_vec, exp_vec());
    end
  endtask

  task automatic test_hold_sat();
    logic [DW-1:0] d;
    d = rand_data();
    step(6'b000000, 0, 1, d, 1, 1);
    for (int i = 1; i <= 20; i++) begin
      step(6'b001100, 0, 1, rand_data(), 0, 0);
      checks++;
      if (out_data !== d || hold_cnt !== 4'((i > HMAX) ? HMAX : i)) begin
        errors++;
        $display("FAIL hold_%0d: data=%h hold=%0d want data=%h hold=%0d", i, out_data,
                 hold_cnt, d, (i > HMAX) ? HMAX : i);
      end
      if (i == HMAX || i == 20) begin
        checks++;
        if (hold_sat !== 1'b1) begin
          errors++;
          $display("FAIL hold_sat_%0d: got %b want 1", i, hold_sat);
        end
      end
    end
    d = rand_data();
    step(6'b000000, 0, 1, d, 0, 0);
    checks++;
    if (hold_cnt !== 4'd0 || hold_sat !== 1'b0 || out_data !== d) begin
      errors++;
      $display("FAIL hold_release: hold=%0d sat=%b data=%h want 0/0/%h", hold_cnt, hold_sat,
               out_data, d);
    end
  endtask

  task automatic test_flush();
    step(6'b000000, 0, 1, rand_data(), 1, 1);
    step(6'b001100, 1, 1, rand_data(), 1, 1);
    checks++;
    if (out_valid !== 1'b0 || out_ds !== 1'b0 || next_ds_o !== 1'b0 || bubble_o !== 1'b1) begin
      errors++;
      $display("FAIL flush: valid=%b ds=%b next_ds=%b bub=%b want 0/0/0/1",
               out_valid, out_ds, next_ds_o, bubble_o);
    end
  endtask

  task automatic test_delay_slot();
    step(6'b000000, 0, 1, rand_data(), 1, 0);
    checks++;
    if (out_ds !== 1'b1) begin
      errors++;
      $display("FAIL ds_capture: got %b want 1", out_ds);
    end
    step(6'b000000, 0, 0, rand_data(), 1, 1);
    checks++;
    if (out_ds !== 1'b0 || out_data !== '0 || next_ds_o !== 1'b0) begin
      errors++;
      $display("FAIL ds_invalid: ds=%b data=%h next_ds=%b want 0/0/0", out_ds, out_data,
               next_ds_o);
    end
  endtask

  task automatic test_perf();
    do_reset();
    for (int i = 0; i < 3; i++) step(6'b000000, 0, 1, rand_data(), 0, 0);
    for (int i = 0; i < 2; i++) step(6'b000100, 0, 1, rand_data(), 0, 0);
    step(6'b000000, 1, 1, rand_data(), 0, 0);
    checks++;
`ifdef PIPE_STAGE_PERF_CNT_EN
    if (perf_captures !== 32'd3 || perf_bubbles !== 32'd3) begin
      errors++;
      $display("FAIL perf: captures=%0d bubbles=%0d want 3/3", perf_captures, perf_bubbles);
    end
`else
    if (perf_captures !== 32'd0 || perf_bubbles !== 32'd0) begin
      errors++;
      $display("FAIL perf_off: captures=%0d bubbles=%0d want 0/0", perf_captures, perf_bubbles);
    end
`endif
  endtask

  task automatic test_random();
    logic [SW-1:0] st;
    int sel;
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: st = 6'b000000;
        3:       st = 6'b000100;
        4, 5, 6: st = 6'b001100;
        7:       st = 6'b001000;
        default: st = 6'($urandom);
      endcase
      step(st, ($urandom_range(0, 15) == 0), 1'($urandom), rand_data(), 1'($urandom),
           1'($urandom));
      checks++;
      if (act_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random_%0d: got %h want %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    rst = 1'b1; stall = '0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
    in_ds = 1'b0; in_next_ds = 1'b0;
    model_reset();
    #2;
    test_reset();
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    test_async_reset();
    test_bubble();
    test_hold_sat();
    test_flush();
    test_delay_slot();
    test_random();
    test_perf();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
